// File: rtl/reg128_write_arbiter_if.sv
// Bundle of the requester handshake and the registered write port of reg128_write_arbiter.
// The arbiter uses the slave view; whatever drives the requests uses the master view.
interface reg128_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 128
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_lock;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic [SRC_W-1:0]              wr_src;
    logic                          locked;

    modport master (
        output req_valid, req_lock, req_data,
        input  req_ready, wr_en, wr_data, wr_src, locked
    );

    modport slave (
        input  req_valid, req_lock, req_data,
        output req_ready, wr_en, wr_data, wr_src, locked
    );
endinterface

// File: rtl/reg128_write_arbiter.sv
// Round-robin arbiter with grant locking in front of a single 128-bit register write port.
// A locked owner keeps the port until it transfers with lock clear or idles for LOCK_TIMEOUT cycles.
module reg128_write_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 128,
    parameter int LOCK_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   areset,
    reg128_write_arbiter_if.slave  bus
);
    localparam int             SRC_W        = $clog2(NUM_REQ);
    localparam logic [7:0]     TIMEOUT_LAST = 8'(LOCK_TIMEOUT - 1);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t                state, state_next;
    logic [SRC_W-1:0]      last_grant, last_next;
    logic [SRC_W-1:0]      owner, owner_next;
    logic [SRC_W-1:0]      grant_idx;
    logic [7:0]            idle_cnt, idle_next;
    logic                  grant_any;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] sel_data;

    // Grant selection: owner only while locked, else nearest valid after last_grant.
    always_comb begin : arbitrate
        int cand;
        cand      = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        if (state == LOCKED) begin
            grant_any = bus.req_valid[owner];
            grant_idx = owner;
        end else begin
            // Walk farthest-to-nearest so the nearest valid requester wins.
            for (int k = NUM_REQ; k >= 1; k--) begin
                cand = (int'(last_grant) + k) % NUM_REQ;
                if (bus.req_valid[SRC_W'(cand)]) begin
                    grant_any = 1'b1;
                    grant_idx = SRC_W'(cand);
                end
            end
        end
    end

    assign xfer          = grant_any && areset;
    assign bus.req_ready = xfer ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin : data_mux
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == SRC_W'(i)) sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin : next_state
        state_next = state;
        owner_next = owner;
        idle_next  = idle_cnt;
        last_next  = xfer ? grant_idx : last_grant;
        case (state)
            ARB: begin
                if (xfer && bus.req_lock[grant_idx]) begin
                    state_next = LOCKED;
                    owner_next = grant_idx;
                    idle_next  = '0;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    idle_next = '0;
                    if (!bus.req_lock[owner]) state_next = ARB;
                end else if (idle_cnt >= TIMEOUT_LAST) begin
                    state_next = ARB;
                    idle_next  = '0;
                end else begin
                    idle_next = idle_cnt + 8'd1;
                end
            end
            default: state_next = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state       <= ARB;
            last_grant  <= SRC_W'(NUM_REQ - 1);
            owner       <= '0;
            idle_cnt    <= '0;
            bus.locked  <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.wr_data <= '0;
            bus.wr_src  <= '0;
        end else begin
            state      <= state_next;
            last_grant <= last_next;
            owner      <= owner_next;
            idle_cnt   <= idle_next;
            bus.locked <= (state_next == LOCKED);
            // Output stage: one-cycle write latency, data/src hold when idle.
            bus.wr_en  <= xfer;
            if (xfer) begin
                bus.wr_data <= sel_data;
                bus.wr_src  <= grant_idx;
            end
        end
    end
endmodule

// File: tb/tb_reg128_write_arbiter.sv
// Randomized and directed bench for reg128_write_arbiter against a behavioural model
// of the grant, lock and write-port rules.
module tb_reg128_write_arbiter;
    localparam int N  = 4;
    localparam int DW = 128;
    localparam int TO = 8;

    logic clk    = 1'b0;
    logic areset = 1'b0;
    always #5 clk = ~clk;

    reg128_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    reg128_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .LOCK_TIMEOUT(TO)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model state
    bit            m_locked;
    int            m_owner, m_last, m_cnt, m_src;
    bit            m_wr_en;
    logic [DW-1:0] m_wr_data;

    logic [N-1:0]  seen_ready;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*DW-1:0] rnd_data();
        logic [N*DW-1:0] d;
        for (int i = 0; i < N*DW/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [N-1:0] model_ready(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        if (!areset) return r;
        if (m_locked) begin
            if (v[m_owner]) r[m_owner] = 1'b1;
            return r;
        end
        for (int k = 1; k <= N; k++) begin
            if (v[(m_last + k) % N]) begin
                r[(m_last + k) % N] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_locked  = 0;
        m_owner   = 0;
        m_last    = N - 1;
        m_cnt     = 0;
        m_wr_en   = 0;
        m_wr_data = '0;
        m_src     = 0;
    endtask

    // One clock cycle: drive at negedge, check grant, clock model, check write port.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic [N*DW-1:0] d);
        logic [N-1:0] r;
        int x;
        bus.req_valid = v;
        bus.req_lock  = l;
        bus.req_data  = d;
        #1;
        r = model_ready(v);
        seen_ready = bus.req_ready;
        chk("req_ready", {{(DW-N){1'b0}}, bus.req_ready}, {{(DW-N){1'b0}}, r});
        x = -1;
        for (int i = 0; i < N; i++) if (r[i]) x = i;
        @(posedge clk);
        m_wr_en = (x >= 0);
        if (x >= 0) begin
            m_wr_data = d[x*DW +: DW];
            m_src     = x;
            m_last    = x;
        end
        if (!m_locked) begin
            if (x >= 0 && l[x]) begin
                m_locked = 1;
                m_owner  = x;
                m_cnt    = 0;
            end
        end else if (v[m_owner]) begin
            m_cnt = 0;
            if (!l[m_owner]) m_locked = 0;
        end else begin
            m_cnt++;
            if (m_cnt >= TO) begin
                m_locked = 0;
                m_cnt    = 0;
            end
        end
        #1;
        chk("wr_en",   DW'(bus.wr_en),  DW'(m_wr_en));
        chk("locked",  DW'(bus.locked), DW'(m_locked));
        chk("wr_data", bus.wr_data,     m_wr_data);
        chk("wr_src",  DW'(bus.wr_src), DW'(m_src));
        @(negedge clk);
    endtask

    task automatic do_reset();
        areset = 1'b0;
        #1;
        model_reset();
        chk("rst_ready",   DW'(bus.req_ready), '0);
        chk("rst_wr_en",   DW'(bus.wr_en),     '0);
        chk("rst_locked",  DW'(bus.locked),    '0);
        chk("rst_wr_data", bus.wr_data,        '0);
        chk("rst_wr_src",  DW'(bus.wr_src),    '0);
        @(posedge clk);
        @(negedge clk);
        areset = 1'b1;
    endtask

    initial begin
        logic [N*DW-1:0] d;
        int stalls;
        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.req_data  = '0;
        seen_ready    = '0;
        do_reset();

        // Round-robin sweep from reset with all requesters valid.
        for (int i = 0; i < N; i++) begin
            step(4'b1111, 4'b0000, rnd_data());
            chk("rr_grant", DW'(seen_ready), DW'(1 << i));
            chk("rr_src",   DW'(bus.wr_src), DW'(i));
            chk("rr_wr_en", DW'(bus.wr_en),  DW'(1));
        end

        // Requester 2 locks and keeps the port for three writes.
        d = rnd_data();
        d[2*DW +: DW] = {16{8'hA5}};
        step(4'b0100, 4'b0100, d);
        chk("lock_grant0", DW'(seen_ready), DW'(4'b0100));
        chk("lock_data",   bus.wr_data,     {16{8'hA5}});
        step(4'b1111, 4'b0100, d);
        chk("lock_grant1", DW'(seen_ready), DW'(4'b0100));
        step(4'b1111, 4'b0000, d);
        chk("lock_grant2", DW'(seen_ready), DW'(4'b0100));
        chk("lock_exit",   DW'(bus.locked), DW'(0));
        step(4'b1111, 4'b0000, rnd_data());
        chk("after_lock",  DW'(seen_ready), DW'(4'b1000));

        // Owner 1 goes idle: others stall until the timeout releases the lock.
        step(4'b0010, 4'b0010, rnd_data());
        chk("to_locked", DW'(bus.locked), DW'(1));
        stalls = 0;
        step(4'b0100, 4'b0000, rnd_data());
        while (seen_ready == '0 && stalls < 20) begin
            stalls++;
            step(4'b0100, 4'b0000, rnd_data());
        end
        chk("to_stalls", DW'(stalls),     DW'(TO));
        chk("to_grant",  DW'(seen_ready), DW'(4'b0100));

        // Single requester with a fixed pattern, then valid drops.
        d = rnd_data();
        d[0 +: DW] = 128'h0123456789ABCDEF0123456789ABCDEF;
        step(4'b0001, 4'b0000, d);
        chk("single_en",   DW'(bus.wr_en),  DW'(1));
        chk("single_data", bus.wr_data,     128'h0123456789ABCDEF0123456789ABCDEF);
        chk("single_src",  DW'(bus.wr_src), DW'(0));
        step(4'b0000, 4'b0000, rnd_data());
        chk("single_drop", DW'(bus.wr_en),  DW'(0));
        chk("single_hold", bus.wr_data,     128'h0123456789ABCDEF0123456789ABCDEF);

        // Reset while locked with a write sitting in the output stage.
        step(4'b0010, 4'b0010, rnd_data());
        step(4'b0010, 4'b0010, rnd_data());
        chk("pre_rst_en",  DW'(bus.wr_en),  DW'(1));
        chk("pre_rst_lck", DW'(bus.locked), DW'(1));
        do_reset();
        step(4'b0000, 4'b0000, rnd_data());
        chk("post_rst_en", DW'(bus.wr_en), DW'(0));
        step(4'b1001, 4'b0000, rnd_data());
        chk("post_rst_grant", DW'(seen_ready), DW'(4'b0001));

        // Owner returns with lock clear on the last idle cycle before timeout.
        step(4'b0001, 4'b0001, rnd_data());
        for (int i = 0; i < TO - 1; i++) begin
            step(4'b0110, 4'b0000, rnd_data());
            chk("edge_stall", DW'(seen_ready), '0);
        end
        step(4'b0111, 4'b0000, rnd_data());
        chk("edge_grant",  DW'(seen_ready), DW'(4'b0001));
        chk("edge_en",     DW'(bus.wr_en),  DW'(1));
        chk("edge_locked", DW'(bus.locked), DW'(0));
        step(4'b0000, 4'b0000, rnd_data());
        chk("edge_nodup",  DW'(bus.wr_en),  DW'(0));

        // Random traffic, with idle stretches to exercise the timeout.
        for (int n = 0; n < 600; n++) begin
            logic [N-1:0] v, l;
            v = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) v = '0;
            l = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
            step(v, l, rnd_data());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg128_write_arbiter.md
REG128_WRITE_ARBITER -- requirements
Module: reg128_write_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing one 128-bit register write port (legal 2..8).
REQ-002 Parameter: DATA_WIDTH, default 128, width of write data.
REQ-003 Parameter: LOCK_TIMEOUT, default 8, idle cycles after which a held lock is released (legal 1..255).
REQ-004 Port: clk  input  1  single clock, all state on rising edge.
REQ-005 Port: areset  input  1  asynchronous active-low reset, clears all state immediately on assertion (low).
REQ-006 Port: req_valid  input  NUM_REQ  per-requester write request.
REQ-007 Port: req_lock  input  NUM_REQ  per-requester hold-grant flag, sampled only on a transfer.
REQ-008 Port: req_data  input  NUM_REQ*DATA_WIDTH  flattened write data, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port: req_ready  output  NUM_REQ  one-hot-or-zero grant, combinational from state and req_valid.
REQ-010 Port: wr_en  output  1  registered write enable to the register's write_enable.
REQ-011 Port: wr_data  output  DATA_WIDTH  registered write data to the register's data_in.
REQ-012 Port: wr_src  output  $clog2(NUM_REQ)  registered index of requester whose data is on wr_data.
REQ-013 Port: locked  output  1  registered, high while state is LOCKED.

Function
REQ-014 Transfer on requester i occurs in a cycle where req_valid[i]=1 and req_ready[i]=1; at most one transfer per cycle.
REQ-015 State machine: ARB and LOCKED only; reset state ARB.
REQ-016 ARB: req_ready asserted for the first valid requester searching round-robin from (last_grant+1) mod NUM_REQ; none if no req_valid.
REQ-017 last_grant updates to the transferring index on every transfer; reset value NUM_REQ-1 so requester 0 has first priority.
REQ-018 ARB -> LOCKED when the transfer has req_lock[i]=1; owner register captures i.
REQ-019 LOCKED: req_ready asserted only for owner and only when req_valid[owner]=1; all other requesters stalled regardless of valid.
REQ-020 LOCKED -> ARB when owner transfers with req_lock[owner]=0 (that transfer still completes).
REQ-021 LOCKED: idle counter increments each cycle req_valid[owner]=0, clears on owner valid; on reaching LOCK_TIMEOUT, next state ARB, counter cleared.
REQ-022 Idle counter saturates, never wraps; cleared on every state entry.
REQ-023 Write latency exactly 1 cycle: transfer in cycle N -> wr_en=1, wr_data=req_data slice, wr_src=i in cycle N+1.
REQ-024 wr_en=0 in any cycle following a cycle without transfer; wr_data and wr_src hold previous values when wr_en=0.
REQ-025 Back-to-back transfers sustain one write per cycle with no bubbles.
REQ-026 Simultaneous: owner transfer with lock=0 and timeout reaching in same cycle -> single exit to ARB, no double action.
REQ-027 req_lock on a non-transfer cycle ignored; req_lock of non-owner ignored in LOCKED.

Reset
REQ-028 areset low: state=ARB, last_grant=NUM_REQ-1, owner=0, idle counter=0, wr_en=0, wr_data=0, wr_src=0, locked=0, all asynchronously.
REQ-029 req_ready=0 for all requesters while areset low.
REQ-030 Reset asserted mid-lock or with a write pending in the output stage discards the pending write (wr_en stays 0 after release until a new transfer).
REQ-031 Deassertion of areset takes effect at next rising clk; first arbitration favours requester 0.

Verification
REQ-032 After reset, req_valid=4'b1111 held 4 cycles, lock=0 -> grants 0,1,2,3 in order; wr_src 0,1,2,3 one cycle later, wr_en high 4 consecutive cycles.
REQ-033 Requester 2 transfers with lock=1 data 0xA5..A5, requesters 0,1,3 valid -> only 2 granted for 3 writes; third with lock=0 -> next grant to 3.
REQ-034 LOCK_TIMEOUT=8, owner 1 drops valid after lock -> others stalled exactly 8 cycles, locked falls, requester 2 granted in following cycle.
REQ-035 Single requester 0 valid with data 0x0123..CDEF -> wr_en=1, wr_data=0x0123..CDEF, wr_src=0 exactly one cycle after transfer; wr_en=0 when valid drops.
REQ-036 areset pulsed low in LOCKED with a transfer in flight -> wr_en=0, locked=0 immediately; after release, requester 0 wins over valid 3.
REQ-037 Owner transfers with lock=0 on the cycle the idle counter would hit LOCK_TIMEOUT -> one exit to ARB, write completes, no duplicate wr_en.
